// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared channel state type and default counter width for the clock divider.
package clk_div_pkg;
  typedef enum logic {IDLE, RUN} ch_state_t;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one programmable clock channel with period/high shadow registers and tick output.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  output logic             gclk,
  output logic             tick,
  output logic             busy
);
  ch_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, p_sh, p_n, h_sh, h_n;
  logic load, gclk_n, tick_n;
  // A new period begins on start, sync, or wrap; periods of 0 or 1 wrap every cycle.
  always_comb begin
    load    = (state == IDLE) || sync || (p_sh < CNT_W'(2)) || (cnt == p_sh - CNT_W'(1));
    p_n     = load ? period : p_sh;
    h_n     = load ? high : h_sh;
    cnt_n   = (!en || load) ? '0 : cnt + CNT_W'(1);
    state_n = en ? RUN : IDLE;
    gclk_n  = en && (cnt_n < h_n);
    tick_n  = en && load && (h_n != '0) && (p_n > CNT_W'(1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      p_sh  <= '0;
      h_sh  <= '0;
      gclk  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      p_sh  <= p_n;
      h_sh  <= h_n;
      gclk  <= gclk_n;
      tick  <= tick_n;
    end
  end
  assign busy = (state == RUN);
endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH independent programmable clock generators; CLK_DIV_GEN_SYNC_EN adds sync_i phase alignment.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef CLK_DIV_GEN_SYNC_EN
  input  logic                    sync_i,
`endif
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH*CNT_W-1:0] high_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       busy_o
);
  logic sync;
`ifdef CLK_DIV_GEN_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_i[c]),
      .sync  (sync),
      .period(period_i[c*CNT_W +: CNT_W]),
      .high  (high_i[c*CNT_W +: CNT_W]),
      .gclk  (clk_o[c]),
      .tick  (tick_o[c]),
      .busy  (busy_o[c])
    );
  end
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed checks of the clock divider channels, edge cases, enable drop and async reset.
module tb_clk_div_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  en_i;
  logic [23:0] period_i, high_i;
  logic [2:0]  clk_o, tick_o, busy_o;
  logic [2:0]  ec, et;
  int          checks = 0, errors = 0;
`ifdef CLK_DIV_GEN_SYNC_EN
  logic        sync_i = 1'b0;
`endif
  clk_div_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef CLK_DIV_GEN_SYNC_EN
    .sync_i  (sync_i),
`endif
    .en_i    (en_i),
    .period_i(period_i),
    .high_i  (high_i),
    .clk_o   (clk_o),
    .tick_o  (tick_o),
    .busy_o  (busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n    = 1'b0;
    en_i     = 3'b000;
    period_i = {8'd4, 8'd5, 8'd4};
    high_i   = {8'd5, 8'd0, 8'd2};
    step;
    step;
    check("rst_clk", clk_o, 3'b000);
    check("rst_tick", tick_o, 3'b000);
    check("rst_busy", busy_o, 3'b000);
    rst_n = 1'b1;
    en_i  = 3'b111;
    // ch0 P4/H2, ch1 H0, ch2 H5>P4
    for (int i = 0; i < 12; i++) begin
      step;
      ec = {1'b1, 1'b0, (i % 4) < 2};
      et = {(i % 4) == 0, 1'b0, (i % 4) == 0};
      check("a_clk", clk_o, ec);
      check("a_tick", tick_o, et);
      check("a_busy", busy_o, 3'b111);
    end
    en_i = 3'b000;
    step;
    check("off_busy", busy_o, 3'b000);
    check("off_clk", clk_o, 3'b000);
    // ch0 P10/H3 switched to P6/H3 mid-period, ch1 P1/H1, ch2 P0/H0
    period_i = {8'd0, 8'd1, 8'd10};
    high_i   = {8'd0, 8'd1, 8'd3};
    en_i     = 3'b111;
    for (int i = 0; i < 28; i++) begin
      step;
      ec = {1'b0, 1'b1, (i < 10) ? (i < 3) : (((i - 10) % 6) < 3)};
      et = {1'b0, 1'b0, (i == 0) || ((i >= 10) && (((i - 10) % 6) == 0))};
      check("b_clk", clk_o, ec);
      check("b_tick", tick_o, et);
      check("b_busy", busy_o, 3'b111);
      if (i == 4) period_i[7:0] = 8'd6;
    end
    en_i = 3'b000;
    step;
    period_i = {8'd0, 8'd0, 8'd4};
    high_i   = {8'd0, 8'd0, 8'd2};
    en_i     = 3'b001;
    step;
    check("c_start_clk", clk_o, 3'b001);
    check("c_start_tick", tick_o, 3'b001);
    en_i = 3'b000;
    step;
    check("c_drop_clk", clk_o, 3'b000);
    check("c_drop_tick", tick_o, 3'b000);
    check("c_drop_busy", busy_o, 3'b000);
    en_i = 3'b001;
    step;
    check("c_re_clk", clk_o, 3'b001);
    check("c_re_tick", tick_o, 3'b001);
    check("c_re_busy", busy_o, 3'b001);
    step;
    check("c_re1_clk", clk_o, 3'b001);
    check("c_re1_tick", tick_o, 3'b000);
    step;
    check("c_re2_clk", clk_o, 3'b000);
    // asynchronous reset while ch0 is in its high phase
    step;
    step;
    check("d_pre_clk", clk_o, 3'b001);
    #3;
    rst_n = 1'b0;
    #1;
    check("d_async_clk", clk_o, 3'b000);
    check("d_async_tick", tick_o, 3'b000);
    check("d_async_busy", busy_o, 3'b000);
    period_i[7:0] = 8'd2;
    high_i[7:0]   = 8'd1;
    step;
    check("d_hold_busy", busy_o, 3'b000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      check("d_rec_clk", clk_o, {2'b00, (i % 2) == 0});
      check("d_rec_tick", tick_o, {2'b00, (i % 2) == 0});
      check("d_rec_busy", busy_o, 3'b001);
    end
`ifdef CLK_DIV_GEN_SYNC_EN
    en_i = 3'b000;
    step;
    period_i = {8'd0, 8'd6, 8'd4};
    high_i   = {8'd0, 8'd2, 8'd1};
    en_i     = 3'b001;
    step;
    step;
    en_i = 3'b011;
    step;
    step;
    step;
    sync_i = 1'b1;
    for (int s = 0; s < 12; s++) begin
      step;
      sync_i = 1'b0;
      ec = {1'b0, (s % 6) < 2, (s % 4) < 1};
      et = {1'b0, (s % 6) == 0, (s % 4) == 0};
      check("e_sync_clk", clk_o, ec);
      check("e_sync_tick", tick_o, et);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent generated clock channels (1..16).
REQ-002 Parameter CNT_W, default 8: width of per-channel period/high-count fields.
REQ-003 clk  input  1  single reference clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en_i  input  NUM_CH  per-channel enable.
REQ-006 period_i  input  NUM_CH*CNT_W  per-channel period P in clk cycles; channel c occupies bits [c*CNT_W +: CNT_W].
REQ-007 high_i  input  NUM_CH*CNT_W  per-channel high time H in clk cycles, same packing.
REQ-008 clk_o  output  NUM_CH  registered generated clock per channel.
REQ-009 tick_o  output  NUM_CH  one-cycle pulse marking the first high cycle of each period.
REQ-010 busy_o  output  NUM_CH  channel in RUN state.

Function
REQ-011 Each channel SHALL be a two-state FSM: IDLE (counter 0, clk_o=0, tick_o=0) and RUN.
REQ-012 IDLE->RUN on the edge sampling en_i[c]=1; that edge loads the P/H shadow registers, sets cnt=0, and drives clk_o=(H>0), tick_o=(H>0), so output is valid one cycle after en_i rises.
REQ-013 In RUN, cnt SHALL increment modulo P_shadow; clk_o=(cnt_next < H_shadow), registered, glitch-free.
REQ-014 Shadow P/H SHALL reload only on the edge where cnt wraps from P_shadow-1 to 0; changes to period_i/high_i mid-period SHALL NOT affect the current period.
REQ-015 tick_o SHALL pulse on every cycle where cnt_next=0 and H_shadow>0.
REQ-016 RUN->IDLE on the edge sampling en_i[c]=0, immediately; clk_o and tick_o SHALL be 0 the following cycle (truncated high phase allowed).
REQ-017 P=0 or P=1: channel SHALL hold clk_o=0 if H=0, else clk_o=1; tick_o=0; busy_o=1.
REQ-018 H>=P (P>=2): clk_o held 1, tick_o pulses once per P cycles.
REQ-019 H=0: clk_o held 0, tick_o never pulses.
REQ-020 Channels SHALL be fully independent; no cross-channel phase relation except under REQ-024.

Reset
REQ-021 rst_n low SHALL asynchronously force all channels to IDLE, cnt=0, shadows=0, clk_o=0, tick_o=0, busy_o=0.
REQ-022 Reset deassertion SHALL be sampled synchronously; the first rising edge with rst_n=1 may already start a channel whose en_i=1.
REQ-023 Reset mid-period SHALL discard shadows; restart reloads from current inputs.

Configuration
REQ-024 Macro CLK_DIV_GEN_SYNC_EN: when defined, adds input sync_i (1 bit); an edge sampling sync_i=1 SHALL force every RUN channel to cnt=0, reload shadows, and assert tick_o where H>0, aligning all phases; IDLE channels unaffected. Sync has priority over natural wrap.
REQ-025 Without CLK_DIV_GEN_SYNC_EN, the sync_i port SHALL be absent and behaviour is REQ-011..REQ-020 only.

Structure
REQ-026 Package clk_div_pkg SHALL hold the IDLE/RUN state enum and default CNT_W constant.
REQ-027 One sub-module clk_div_ch SHALL implement a single channel; clk_div_gen instantiates NUM_CH copies via generate and handles port slicing and sync fan-out.

Verification
REQ-028 P=4, H=2, en_i held 1 -> clk_o pattern 1100 repeating, tick_o every 4th cycle, first high one cycle after en_i.
REQ-029 P=10, H=3 -> 30% duty: 3 high, 7 low, period 10; change to P=6,H=3 mid-period -> current period completes 3/7, next period is 3/3.
REQ-030 Edge cases: H=0 -> clk_o constant 0; H=5,P=4 -> clk_o constant 1 with tick every 4; P=1,H=1 -> constant 1, no tick.
REQ-031 en_i dropped during high phase -> clk_o=0 next cycle, busy_o=0; re-enable restarts at cnt=0.
REQ-032 rst_n pulsed low mid-run (asynchronous to clk) -> all outputs 0 immediately; recovery per REQ-012.
REQ-033 With CLK_DIV_GEN_SYNC_EN: channels P=4 and P=6 free-running, sync_i pulse -> both tick_o assert on the same following cycle.
